// File: rtl/arm_pkg.sv
// Shared definitions for the pipelined ARM core: condition codes, flag bit
// positions and the gated control bundle carried from Execute into Memory.
package arm_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic pc_src;
        logic reg_write;
        logic mem_write;
    } m_ctrl_t;

endpackage

// File: rtl/cond_eval.sv
// Purely combinational condition check: one 16:1 selection of flag terms
// indexed by the instruction condition field.
module cond_eval
    import arm_pkg::*;
(
    input  logic [3:0] CondE,
    input  logic [3:0] Flags,
    output logic       CondExE
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        CondExE = 1'b1;
        case (CondE)
            COND_EQ: CondExE = z;
            COND_NE: CondExE = ~z;
            COND_CS: CondExE = c;
            COND_CC: CondExE = ~c;
            COND_MI: CondExE = n;
            COND_PL: CondExE = ~n;
            COND_VS: CondExE = v;
            COND_VC: CondExE = ~v;
            COND_HI: CondExE = c & ~z;
            COND_LS: CondExE = ~c | z;
            COND_GE: CondExE = ~(n ^ v);
            COND_LT: CondExE = n ^ v;
            COND_GT: CondExE = ~z & ~(n ^ v);
            COND_LE: CondExE = z | (n ^ v);
            COND_AL: CondExE = 1'b1;
            COND_NV: CondExE = 1'b1;
            default: CondExE = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: architectural flag register, condition gating
// of the write/branch controls, and the E->M control pipeline register.
module cond_unit
    import arm_pkg::*;
#(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       flush,
    input  logic [3:0] CondE,
    input  logic [1:0] FlagWriteE,
    input  logic [3:0] ALUFlags,
    input  logic       PCSrcE,
    input  logic       RegWriteE,
    input  logic       MemWriteE,
    output logic       CondExE,
    output logic       PCSrcGE,
    output logic [3:0] Flags,
    output logic       PCSrcM,
    output logic       RegWriteM,
    output logic       MemWriteM
);

    logic       live;
    logic [3:0] flags_reg;
    logic [3:0] flags_next;
    m_ctrl_t    m_reg;
    m_ctrl_t    m_next;

    // Evaluated against the stored flags only; the ALU result of this same
    // instruction is never forwarded into its own condition.
    cond_eval u_cond_eval (
        .CondE   (CondE),
        .Flags   (flags_reg),
        .CondExE (CondExE)
    );

    assign live    = CondExE & ~flush;
    assign PCSrcGE = PCSrcE & CondExE;

    // FlagWriteE[1] owns {N,Z}, FlagWriteE[0] owns {C,V}.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_flag_half
            assign flags_next[2*gi +: 2] = (live & FlagWriteE[gi]) ? ALUFlags[2*gi +: 2]
                                                                  : flags_reg[2*gi +: 2];
        end
    endgenerate

    always_comb begin
        m_next           = '0;
        m_next.pc_src    = PCSrcE    & live;
        m_next.reg_write = RegWriteE & live;
        m_next.mem_write = MemWriteE & live;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_reg <= FLAG_RESET;
            m_reg     <= '0;
        end else if (en) begin
            flags_reg <= flags_next;
            m_reg     <= m_next;
        end
    end

    assign Flags     = flags_reg;
    assign PCSrcM    = m_reg.pc_src;
    assign RegWriteM = m_reg.reg_write;
    assign MemWriteM = m_reg.mem_write;

endmodule
